sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator_pkg.sv | 26 ++
 rtl/accum_beat_counter.sv | 40 ++++
 rtl/sum_accumulator.sv | 151 +++++++++++++++
 tb/tb_sum_accumulator.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum accumulator block.
//   state_t  : frame FSM states (IDLE, ACCUM, HOLD)
//   clog2    : ceiling log2, used to size the accumulator and beat counter
//   DEFAULT_DATA_W / DEFAULT_COUNT : default sum width and beats per frame
package sum_accumulator_pkg;

    localparam int DEFAULT_DATA_W = 9;
    localparam int DEFAULT_COUNT  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/accum_beat_counter.sv
// Beat counter for one accumulation frame.
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : synchronous return to zero (frame abort or frame done)
//   load       : first beat of a frame, counter becomes 1
//   inc        : further accepted beat, counter increments
//   last       : the next accepted beat completes the frame (cnt == COUNT-1)
module accum_beat_counter
    import sum_accumulator_pkg::*;
#(
    parameter int COUNT = DEFAULT_COUNT,
    parameter int CNT_W = clog2(COUNT + 32'sd1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt_r;

    // Beat count register: clear beats load beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clear) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= CNT_W'(1);
        end else if (inc) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == CNT_W'(COUNT - 32'sd1));

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned sums from an upstream adder into one frame total.
//   clk, rst_n          : clock and asynchronous active-low reset
//   clear               : synchronous frame abort, wins over both handshakes
//   in_valid/in_ready   : input handshake for in_sum (DATA_W bits)
//   out_valid/out_ready : output handshake for out_acc (ACC_W bits)
//   out_busy            : a partial frame is held (state ACCUM)
// in_ready, out_valid and out_busy are plain flops updated with the state, so
// neither handshake input reaches an output combinationally.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int COUNT  = DEFAULT_COUNT,
    parameter int ACC_W  = DATA_W + clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_busy
);

    localparam bit SINGLE_BEAT = (COUNT == 32'sd1);

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] out_acc_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             out_busy_r;

    logic             beat_s;
    logic             out_xfer_s;
    logic [ACC_W-1:0] in_ext_s;
    logic [ACC_W-1:0] acc_sum_s;
    logic             cnt_clear_s;
    logic             cnt_load_s;
    logic             cnt_inc_s;
    logic             last_s;

    assign beat_s     = in_valid && in_ready_r;
    assign out_xfer_s = out_valid_r && out_ready;
    assign in_ext_s   = ACC_W'(in_sum);
    assign acc_sum_s  = acc_r + in_ext_s;

    // Beat counter control: abort or completed transfer zeroes it, a beat in
    // IDLE starts a frame at 1, a beat in ACCUM advances it.
    always_comb begin
        cnt_clear_s = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_inc_s   = 1'b0;
        if (clear || out_xfer_s) begin
            cnt_clear_s = 1'b1;
        end else if (beat_s) begin
            if (state_r == IDLE) begin
                cnt_load_s = 1'b1;
            end else begin
                cnt_inc_s = 1'b1;
            end
        end else begin
            cnt_clear_s = 1'b0;
        end
    end

    accum_beat_counter #(
        .COUNT (COUNT)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear_s),
        .load  (cnt_load_s),
        .inc   (cnt_inc_s),
        .last  (last_s)
    );

    // Frame FSM with datapath and registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            out_acc_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_busy_r  <= 1'b0;
        end else if (clear) begin
            state_r     <= IDLE;
            acc_r       <= '0;
            out_acc_r   <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (beat_s) begin
                        acc_r <= in_ext_s;
                        if (SINGLE_BEAT) begin
                            // A one-beat frame is complete on its first beat.
                            state_r     <= HOLD;
                            out_acc_r   <= in_ext_s;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_busy_r  <= 1'b0;
                        end else begin
                            state_r    <= ACCUM;
                            out_busy_r <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_s) begin
                        acc_r <= acc_sum_s;
                        if (last_s) begin
                            state_r     <= HOLD;
                            out_acc_r   <= acc_sum_s;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_busy_r  <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (out_xfer_s) begin
                        state_r     <= IDLE;
                        acc_r       <= '0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    acc_r       <= '0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    out_busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_busy  = out_busy_r;
    assign out_acc   = out_acc_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: a COUNT=16 instance for the frame tests
// and a COUNT=1 instance for the single-beat frame.
module tb_sum_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_sum;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_acc;
    logic        out_busy;

    logic        clear1;
    logic        in_valid1;
    logic        in_ready1;
    logic [8:0]  in_sum1;
    logic        out_valid1;
    logic        out_ready1;
    logic [8:0]  out_acc1;
    logic        out_busy1;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        v;
        logic [8:0]  s;
        logic        exp_busy;
        logic        exp_ov;
        logic [12:0] exp_acc;
    } vec_t;

    vec_t tbl [32];
    int   n_rows;

    sum_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_busy  (out_busy)
    );

    sum_accumulator #(.DATA_W(9), .COUNT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_sum    (in_sum1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_acc   (out_acc1),
        .out_busy  (out_busy1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, pass one rising edge, then settle 1 time unit for sampling.
    task automatic tick(input logic v, input logic [8:0] s, input logic ordy, input logic clr);
        in_valid  = v;
        in_sum    = s;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sum;
        int n_out;
        logic [12:0] last_acc;

        n_cmp = 0; n_bad = 0;
        clk = 1'b0; rst_n = 1'b0; clear = 1'b0;
        in_valid = 1'b0; in_sum = 9'd0; out_ready = 1'b0;
        clear1 = 1'b0; in_valid1 = 1'b0; in_sum1 = 9'd0; out_ready1 = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_busy", out_busy, 1'b0);
        chk("rst_out_acc", out_acc, 13'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cnt", dut.u_counter.cnt_r, 5'd0);
        rst_n = 1'b1;

        // Test 1: 16 x 510 back-to-back, first beat on first edge after reset
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 9'd510, 1'b1, 1'b0);
            if (i < 15) begin
                chk("t1_busy", out_busy, 1'b1);
                chk("t1_no_valid", out_valid, 1'b0);
            end
        end
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_acc", out_acc, 13'd8160);
        chk("t1_hold_in_ready", in_ready, 1'b0);
        chk("t1_hold_busy", out_busy, 1'b0);
        tick(1'b0, 9'd0, 1'b1, 1'b0);
        chk("t1_valid_drop", out_valid, 1'b0);
        chk("t1_in_ready_back", in_ready, 1'b1);

        // Test 2: beats 0..15 with gaps carrying junk data
        sum = 0;
        n_rows = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 3 == 1) begin
                tbl[n_rows] = '{1'b0, 9'd333, 1'b1, 1'b0, 13'(sum)};
                n_rows++;
            end
            sum = sum + k;
            tbl[n_rows] = '{1'b1, 9'(k), (k < 15), (k == 15), 13'(sum)};
            n_rows++;
        end
        for (int r = 0; r < n_rows; r++) begin
            tick(tbl[r].v, tbl[r].s, 1'b1, 1'b0);
            chk("t2_busy", out_busy, tbl[r].exp_busy);
            chk("t2_valid", out_valid, tbl[r].exp_ov);
            chk("t2_acc_reg", dut.acc_r, tbl[r].exp_acc);
        end
        chk("t2_out_acc", out_acc, 13'd120);
        tick(1'b0, 9'd0, 1'b1, 1'b0);
        chk("t2_valid_drop", out_valid, 1'b0);

        // Test 3: 16 x 1 with downstream stalled for 5 cycles
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 9'd1, 1'b0, 1'b0);
        end
        chk("t3_valid", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 9'd99, 1'b0, 1'b0);
            chk("t3_stall_valid", out_valid, 1'b1);
            chk("t3_stall_in_ready", in_ready, 1'b0);
            chk("t3_stall_acc", out_acc, 13'd16);
        end
        tick(1'b1, 9'd99, 1'b1, 1'b0);
        chk("t3_xfer_valid", out_valid, 1'b0);
        chk("t3_xfer_in_ready", in_ready, 1'b1);
        chk("t3_no_beat_in_hold", out_busy, 1'b0);

        // Test 4: 7 x 100, clear (with a beat present), then 16 x 1
        n_out = 0;
        last_acc = 13'd0;
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 9'd100, 1'b1, 1'b0);
            if (out_valid) n_out++;
        end
        tick(1'b1, 9'd100, 1'b1, 1'b1);
        chk("t4_clr_busy", out_busy, 1'b0);
        chk("t4_clr_valid", out_valid, 1'b0);
        chk("t4_clr_in_ready", in_ready, 1'b1);
        chk("t4_clr_acc", dut.acc_r, 13'd0);
        chk("t4_clr_cnt", dut.u_counter.cnt_r, 5'd0);
        for (int i = 0; i < 17; i++) begin
            tick((i < 16), 9'd1, 1'b1, 1'b0);
            if (out_valid) begin
                n_out++;
                last_acc = out_acc;
            end
        end
        tick(1'b0, 9'd0, 1'b1, 1'b0);
        if (out_valid) n_out++;
        chk("t4_out_count", n_out, 32'd1);
        chk("t4_out_acc", last_acc, 13'd16);

        // Test 5: asynchronous reset after 9 x 300, then 16 x 2
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 9'd300, 1'b1, 1'b0);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", out_busy, 1'b0);
        chk("t5_rst_valid", out_valid, 1'b0);
        chk("t5_rst_acc", out_acc, 13'd0);
        chk("t5_rst_in_ready", in_ready, 1'b1);
        chk("t5_rst_cnt", dut.u_counter.cnt_r, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 9'd2, 1'b1, 1'b0);
        end
        chk("t5_valid", out_valid, 1'b1);
        chk("t5_acc", out_acc, 13'd32);
        tick(1'b0, 9'd0, 1'b1, 1'b0);
        chk("t5_valid_drop", out_valid, 1'b0);

        // Clear while holding a finished frame discards the output transfer
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 9'd3, 1'b0, 1'b0);
        end
        chk("hc_valid", out_valid, 1'b1);
        tick(1'b0, 9'd0, 1'b1, 1'b1);
        chk("hc_valid_drop", out_valid, 1'b0);
        chk("hc_in_ready", in_ready, 1'b1);

        // Test 6: COUNT=1, beats 5 then 7 offered back-to-back
        in_valid1 = 1'b1; in_sum1 = 9'd5; out_ready1 = 1'b1;
        tick(1'b0, 9'd0, 1'b0, 1'b0);
        chk("t6_valid_a", out_valid1, 1'b1);
        chk("t6_acc_a", out_acc1, 9'd5);
        chk("t6_in_ready_a", in_ready1, 1'b0);
        chk("t6_busy_a", out_busy1, 1'b0);
        in_sum1 = 9'd7;
        tick(1'b0, 9'd0, 1'b0, 1'b0);
        chk("t6_gap_valid", out_valid1, 1'b0);
        chk("t6_gap_in_ready", in_ready1, 1'b1);
        tick(1'b0, 9'd0, 1'b0, 1'b0);
        chk("t6_valid_b", out_valid1, 1'b1);
        chk("t6_acc_b", out_acc1, 9'd7);
        in_valid1 = 1'b0;
        tick(1'b0, 9'd0, 1'b0, 1'b0);
        chk("t6_valid_drop", out_valid1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
